pll_reset_sequencer: RTL and testbench

Sits directly downstream of the top_pll PLL wrapper.
- Drives the PLL's active-low reset.
- Synchronises and qualifies the PLL LOCK output, and releases the sump2 core reset only after lock has been stable for a set time.
- On lock loss, re-asserts core reset, re-sequences the PLL, and keeps saturating event counters for status readout.
- Runs entirely on REFERENCECLK, because the PLL output clock is not trustworthy before lock.

---
 rtl/pll_rst_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared state encodings, default parameters and width helper for the PLL reset sequencer.
package pll_rst_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_PLL_RST   = 2'd0;
    localparam state_t ST_WAIT_LOCK = 2'd1;
    localparam state_t ST_STABLE    = 2'd2;
    localparam state_t ST_RUN       = 2'd3;

    localparam int unsigned DEF_PLL_RST_CYCLES     = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT       = 65536;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_CNT_W              = 8;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving from another clock domain.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Metastability stage followed by the settled stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset, qualifies lock, and gates the core reset on a stable lock.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned CNT_W              = DEF_CNT_W
) (
    input  logic             REFERENCECLK,
    input  logic             RESETB,
    input  logic             LOCK,
    input  logic             CLR_CNT,
    output logic             PLL_RESETB,
    output logic             SYS_RESETN,
    output logic             READY,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] LOCK_LOSS_CNT,
    output logic [CNT_W-1:0] RETRY_CNT
);

    localparam int unsigned RST_W  = clog2_min1(PLL_RST_CYCLES);
    localparam int unsigned TMO_W  = clog2_min1(LOCK_TIMEOUT);
    localparam int unsigned STAB_W = clog2_min1(LOCK_STABLE_CYCLES);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              lock_s;
    state_t            state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [TMO_W-1:0]  tmo_inc;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              pll_resetb_q, pll_resetb_d;
    logic              sys_resetn_q, sys_resetn_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic              loss_inc;
    logic              retry_inc;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (REFERENCECLK),
        .rst_n (RESETB),
        .d     (LOCK),
        .q     (lock_s)
    );

    // Next-state and registered-output decode; timeout counter holds at its last value.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        stab_cnt_d   = stab_cnt_q;
        pll_resetb_d = pll_resetb_q;
        sys_resetn_d = 1'b0;
        ready_d      = 1'b0;
        loss_inc     = 1'b0;
        retry_inc    = 1'b0;
        tmo_inc      = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);

        case (state_q)
            ST_PLL_RST: begin
                pll_resetb_d = 1'b0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d      = ST_WAIT_LOCK;
                    rst_cnt_d    = '0;
                    tmo_cnt_d    = '0;
                    stab_cnt_d   = '0;
                    pll_resetb_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                pll_resetb_d = 1'b1;
                tmo_cnt_d    = tmo_inc;
                if (lock_s) begin
                    state_d    = ST_STABLE;
                    stab_cnt_d = STAB_W'(1);
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = ST_PLL_RST;
                    rst_cnt_d    = '0;
                    pll_resetb_d = 1'b0;
                    retry_inc    = 1'b1;
                end
            end
            ST_STABLE: begin
                pll_resetb_d = 1'b1;
                tmo_cnt_d    = tmo_inc;
                if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = ST_PLL_RST;
                    rst_cnt_d    = '0;
                    pll_resetb_d = 1'b0;
                    retry_inc    = 1'b1;
                end else if (!lock_s) begin
                    state_d    = ST_WAIT_LOCK;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d      = ST_RUN;
                    tmo_cnt_d    = '0;
                    stab_cnt_d   = '0;
                    sys_resetn_d = 1'b1;
                    ready_d      = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            default: begin
                pll_resetb_d = 1'b1;
                sys_resetn_d = 1'b1;
                ready_d      = 1'b1;
                if (!lock_s) begin
                    state_d      = ST_PLL_RST;
                    rst_cnt_d    = '0;
                    pll_resetb_d = 1'b0;
                    sys_resetn_d = 1'b0;
                    ready_d      = 1'b0;
                    loss_inc     = 1'b1;
                end
            end
        endcase
    end

    // Saturating status counters; a clear beats a coincident increment.
    always_comb begin
        loss_cnt_d  = loss_cnt_q;
        retry_cnt_d = retry_cnt_q;
        if (CLR_CNT) begin
            loss_cnt_d  = '0;
            retry_cnt_d = '0;
        end else begin
            if (loss_inc && (loss_cnt_q != CNT_MAX)) begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
            if (retry_inc && (retry_cnt_q != CNT_MAX)) begin
                retry_cnt_d = retry_cnt_q + CNT_W'(1);
            end
        end
    end

    // State, counters and outputs; reset forces the safe state asynchronously.
    always_ff @(posedge REFERENCECLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q      <= ST_PLL_RST;
            rst_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            stab_cnt_q   <= '0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            loss_cnt_q   <= '0;
            retry_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            stab_cnt_q   <= stab_cnt_d;
            pll_resetb_q <= pll_resetb_d;
            sys_resetn_q <= sys_resetn_d;
            ready_q      <= ready_d;
            loss_cnt_q   <= loss_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    assign PLL_RESETB    = pll_resetb_q;
    assign SYS_RESETN    = sys_resetn_q;
    assign READY         = ready_q;
    assign STATE         = state_q;
    assign LOCK_LOSS_CNT = loss_cnt_q;
    assign RETRY_CNT     = retry_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: scenario tables, corner sequences and a random run against a reference model.
module tb_pll_reset_sequencer;

    localparam int P_RST  = 4;
    localparam int P_TMO  = 32;
    localparam int P_STAB = 8;
    localparam int P_CW   = 4;
    localparam int P_MAX  = 15;

    logic        clk;
    logic        RESETB;
    logic        LOCK;
    logic        CLR_CNT;
    logic        PLL_RESETB;
    logic        SYS_RESETN;
    logic        READY;
    logic [1:0]  STATE;
    logic [3:0]  LOCK_LOSS_CNT;
    logic [3:0]  RETRY_CNT;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_TIMEOUT       (P_TMO),
        .LOCK_STABLE_CYCLES (P_STAB),
        .CNT_W              (P_CW)
    ) dut (
        .REFERENCECLK  (clk),
        .RESETB        (RESETB),
        .LOCK          (LOCK),
        .CLR_CNT       (CLR_CNT),
        .PLL_RESETB    (PLL_RESETB),
        .SYS_RESETN    (SYS_RESETN),
        .READY         (READY),
        .STATE         (STATE),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT),
        .RETRY_CNT     (RETRY_CNT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // Reference model: lock history, reset progress, elapsed lock-wait time, consecutive-lock run.
    bit m_s1, m_s2, m_released, m_run;
    int m_rst_done, m_elapsed, m_consec, m_loss, m_retry;

    typedef struct {
        int         at;
        logic       pll;
        logic [1:0] st;
        logic [3:0] retry;
    } s1_vec_t;

    typedef struct {
        int         at;
        logic       lk;
        logic       sys;
        logic       rdy;
        logic [1:0] st;
    } seg_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_released = 0; m_run = 0;
        m_rst_done = 0; m_elapsed = 0; m_consec = 0; m_loss = 0; m_retry = 0;
    endtask

    task automatic model_step();
        bit ls, inc_loss, inc_retry, restart, tmo;
        ls = m_s2; m_s2 = m_s1; m_s1 = LOCK;
        inc_loss = 0; inc_retry = 0; restart = 0;
        if (!m_released) begin
            m_rst_done++;
            if (m_rst_done == P_RST) begin
                m_released = 1; m_elapsed = 0; m_consec = 0;
            end
        end else if (m_run) begin
            if (!ls) begin inc_loss = 1; restart = 1; end
        end else begin
            tmo = (m_elapsed >= P_TMO - 1);
            if (m_consec == 0) begin
                if (ls) m_consec = 1;
                else if (tmo) begin inc_retry = 1; restart = 1; end
            end else if (tmo) begin
                inc_retry = 1; restart = 1;
            end else if (!ls) begin
                m_consec = 0;
            end else if (m_consec == P_STAB - 1) begin
                m_run = 1;
            end else begin
                m_consec++;
            end
            m_elapsed++;
        end
        if (restart) begin m_released = 0; m_run = 0; m_rst_done = 0; end
        if (CLR_CNT) begin
            m_loss = 0; m_retry = 0;
        end else begin
            if (inc_loss && m_loss < P_MAX) m_loss++;
            if (inc_retry && m_retry < P_MAX) m_retry++;
        end
    endtask

    function automatic logic [12:0] model_vec();
        logic [1:0] st;
        st = !m_released ? 2'd0 : m_run ? 2'd3 : (m_consec > 0) ? 2'd2 : 2'd1;
        return {m_released, m_run, m_run, st, 4'(m_loss), 4'(m_retry)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {PLL_RESETB, SYS_RESETN, READY, STATE, LOCK_LOSS_CNT, RETRY_CNT};
    endfunction

    // One clock edge: drive inputs, advance model, compare everything just after the edge.
    task automatic tick(input logic lk, input logic cl);
        LOCK = lk; CLR_CNT = cl;
        @(posedge clk);
        model_step();
        edge_no++;
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic reset_assert();
        RESETB = 1'b0;
        model_reset();
    endtask

    task automatic reset_release();
        LOCK = 1'b0; CLR_CNT = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        RESETB = 1'b1;
        edge_no = 0;
    endtask

    task automatic run_segs(input seg_t tab[$], input string name);
        foreach (tab[i]) begin
            while (edge_no < tab[i].at) tick(tab[i].lk, 1'b0);
            check($sformatf("%s_seg%0d", name, i), 32'({SYS_RESETN, READY, STATE}),
                  32'({tab[i].sys, tab[i].rdy, tab[i].st}));
        end
    endtask

    task automatic go_run();
        int k;
        k = 0;
        while (READY !== 1'b1 && k < 100) begin tick(1'b1, 1'b0); k++; end
        check("reach_run", 32'(READY), 32'd1);
    endtask

    task automatic lose_lock(input logic clr_on_inc);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, clr_on_inc);
    endtask

    initial begin
        s1_vec_t s1_tab[$];
        seg_t    s2_tab[$];
        seg_t    s3_tab[$];
        int      idx;
        int      run_left;
        logic    cur_lock;

        s1_tab = '{
            '{1,   1'b0, 2'd0, 4'd0},
            '{3,   1'b0, 2'd0, 4'd0},
            '{4,   1'b1, 2'd1, 4'd0},
            '{35,  1'b1, 2'd1, 4'd0},
            '{36,  1'b0, 2'd0, 4'd1},
            '{39,  1'b0, 2'd0, 4'd1},
            '{40,  1'b1, 2'd1, 4'd1},
            '{72,  1'b0, 2'd0, 4'd2},
            '{540, 1'b0, 2'd0, 4'd15},
            '{576, 1'b0, 2'd0, 4'd15}
        };
        s2_tab = '{
            '{4,  1'b0, 1'b0, 1'b0, 2'd1},
            '{6,  1'b1, 1'b0, 1'b0, 2'd1},
            '{7,  1'b1, 1'b0, 1'b0, 2'd2},
            '{13, 1'b1, 1'b0, 1'b0, 2'd2},
            '{14, 1'b1, 1'b1, 1'b1, 2'd3},
            '{20, 1'b1, 1'b1, 1'b1, 2'd3}
        };
        s3_tab = '{
            '{4,  1'b0, 1'b0, 1'b0, 2'd1},
            '{6,  1'b1, 1'b0, 1'b0, 2'd1},
            '{7,  1'b1, 1'b0, 1'b0, 2'd2},
            '{9,  1'b1, 1'b0, 1'b0, 2'd2},
            '{10, 1'b0, 1'b0, 1'b0, 2'd2},
            '{11, 1'b1, 1'b0, 1'b0, 2'd2},
            '{12, 1'b1, 1'b0, 1'b0, 2'd1},
            '{13, 1'b1, 1'b0, 1'b0, 2'd2},
            '{19, 1'b1, 1'b0, 1'b0, 2'd2},
            '{20, 1'b1, 1'b1, 1'b1, 2'd3}
        };

        RESETB = 1'b0; LOCK = 1'b0; CLR_CNT = 1'b0;
        model_reset();
        #1;
        check("reset_values", 32'(dut_vec()), 32'd0);
        reset_release();

        // Lock never arrives: reset timing, retries and saturation.
        idx = 0;
        while (edge_no < 580) begin
            tick(1'b0, 1'b0);
            if (idx < s1_tab.size() && edge_no == s1_tab[idx].at) begin
                check($sformatf("no_lock_%0d", s1_tab[idx].at), 32'({PLL_RESETB, STATE, RETRY_CNT}),
                      32'({s1_tab[idx].pll, s1_tab[idx].st, s1_tab[idx].retry}));
                idx++;
            end
        end

        // Clean lock, then loss of lock and re-lock.
        reset_assert();
        reset_release();
        run_segs(s2_tab, "lock_held");
        tick(1'b0, 1'b0);
        check("loss_t",   32'({SYS_RESETN, STATE}), 32'({1'b1, 2'd3}));
        tick(1'b0, 1'b0);
        check("loss_t1",  32'({SYS_RESETN, STATE}), 32'({1'b1, 2'd3}));
        tick(1'b0, 1'b0);
        check("loss_t2",  32'({SYS_RESETN, READY, STATE, LOCK_LOSS_CNT}), 32'({1'b0, 1'b0, 2'd0, 4'd1}));
        while (edge_no < 26) tick(1'b0, 1'b0);
        check("loss_pll_low", 32'(PLL_RESETB), 32'd0);
        tick(1'b0, 1'b0);
        check("loss_pll_high", 32'({PLL_RESETB, STATE}), 32'({1'b1, 2'd1}));
        while (edge_no < 36) tick(1'b1, 1'b0);
        check("relock_early", 32'({SYS_RESETN, STATE}), 32'({1'b0, 2'd2}));
        tick(1'b1, 1'b0);
        check("relock_run", 32'({SYS_RESETN, READY, STATE}), 32'({1'b1, 1'b1, 2'd3}));

        // Lock glitch inside the stable window restarts qualification.
        reset_assert();
        reset_release();
        run_segs(s3_tab, "lock_glitch");
        check("glitch_retry", 32'(RETRY_CNT), 32'd0);

        // Clear coincident with a lock-loss increment.
        reset_assert();
        reset_release();
        for (int i = 0; i < 3; i++) begin
            go_run();
            lose_lock(1'b0);
        end
        check("loss_three", 32'(LOCK_LOSS_CNT), 32'd3);
        go_run();
        lose_lock(1'b1);
        check("clr_wins", 32'(LOCK_LOSS_CNT), 32'd0);

        // Asynchronous reset in STABLE.
        reset_assert();
        reset_release();
        repeat (5) tick(1'b1, 1'b0);
        check("mid_stable", 32'(STATE), 32'd2);
        #3;
        reset_assert();
        #1;
        check("async_in_stable", 32'(dut_vec()), 32'd0);
        reset_release();

        // Asynchronous reset in RUN with a non-zero counter.
        go_run();
        lose_lock(1'b0);
        go_run();
        check("run_loss_one", 32'(LOCK_LOSS_CNT), 32'd1);
        #3;
        reset_assert();
        #1;
        check("async_in_run", 32'(dut_vec()), 32'd0);
        reset_release();
        repeat (3) tick(1'b1, 1'b0);
        check("restart_rst", 32'({PLL_RESETB, STATE}), 32'({1'b0, 2'd0}));
        tick(1'b1, 1'b0);
        check("restart_wait", 32'({PLL_RESETB, STATE, LOCK_LOSS_CNT, RETRY_CNT}), 32'({1'b1, 2'd1, 8'd0}));

        // Randomised lock behaviour with occasional clears and asynchronous resets.
        reset_assert();
        reset_release();
        run_left = 0;
        cur_lock = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (run_left == 0) begin
                cur_lock = ($urandom_range(0, 3) != 0);
                run_left = $urandom_range(1, 45);
            end
            run_left--;
            tick(cur_lock, ($urandom_range(0, 63) == 0));
            if ($urandom_range(0, 999) == 0) begin
                #2;
                reset_assert();
                #1;
                check("random_async", 32'(dut_vec()), 32'd0);
                reset_release();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
